// File: rtl/spi_byte_master_pkg.sv
// Shared types and helpers for the SPI byte master.
package spi_byte_master_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned MAX_BYTES = 4;
  localparam int unsigned DATA_W    = BYTE_W * MAX_BYTES;

  typedef enum logic [2:0] {
    StIdle,
    StCsSetup,
    StTx,
    StRx,
    StCsHold,
    StDone
  } state_e;

  // Requests above capacity saturate at MAX_BYTES.
  function automatic logic [2:0] clamp_count(input logic [3:0] cnt);
    return (cnt > 4'(MAX_BYTES)) ? 3'(MAX_BYTES) : cnt[2:0];
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCK generator: half-period counter that toggles the SCK phase every CLK_DIV clocks while run.
module spi_sck_gen #(
  parameter int unsigned CLK_DIV = 50
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic run,
  output logic sck,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int unsigned CntW = $clog2(CLK_DIV);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            phase_q, phase_d;
  logic            wrap;

  assign wrap = run && (cnt_q == CntW'(CLK_DIV - 1));

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!run) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (wrap) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign sck       = phase_q;
  assign rise_tick = wrap & ~phase_q;
  assign fall_tick = wrap & phase_q;

endmodule

// File: rtl/spi_byte_master.sv
// Byte-oriented SPI master (mode 1, MSB first): up to 4 tx bytes then up to 4 rx bytes per transfer.
// Define SPI_LOOPBACK_EN to feed the rx sampler from mosi instead of the miso pin.
module spi_byte_master
  import spi_byte_master_pkg::*;
#(
  parameter int unsigned CLK_DIV = 50
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              start_trans,
  input  logic [3:0]        in_bytes_count,
  input  logic [3:0]        out_bytes_count,
  input  logic [DATA_W-1:0] in_bytes,
  input  logic              miso,
  output logic              sck_out,
  output logic              mosi,
  output logic              cs,
  output logic [DATA_W-1:0] out_bytes,
  output logic              trans_done
);

  localparam int unsigned WaitW = $clog2(CLK_DIV);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [DATA_W-1:0]   out_q, out_d;
  logic [2:0]          ntx_q, ntx_d;
  logic [2:0]          nrx_q, nrx_d;
  logic [4:0]          bit_cnt_q, bit_cnt_d;
  logic [WaitW-1:0]    wait_q, wait_d;
  logic                mosi_q, mosi_d;
  logic                cs_q, cs_d;
  logic                done_q, done_d;
  logic [1:0]          sync_q;
  logic                prev_q;

  logic start_edge, sck_run, rise_tick, fall_tick, sck_lvl;
  logic wait_end, last_tx, last_rx, din;
  logic [5:0] tx_bits, rx_bits;

  assign start_edge = sync_q[1] & ~prev_q;
  assign sck_run    = (state_q == StTx) || (state_q == StRx);
  assign wait_end   = (wait_q == WaitW'(CLK_DIV - 1));
  assign tx_bits    = {ntx_q, 3'b000};
  assign rx_bits    = {nrx_q, 3'b000};
  assign last_tx    = ({1'b0, bit_cnt_q} == tx_bits - 6'd1);
  assign last_rx    = ({1'b0, bit_cnt_q} == rx_bits - 6'd1);

`ifdef SPI_LOOPBACK_EN
  assign din = mosi_q;
`else
  assign din = miso;
`endif

  spi_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .run       (sck_run),
    .sck       (sck_lvl),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    out_d     = out_q;
    ntx_d     = ntx_q;
    nrx_d     = nrx_q;
    bit_cnt_d = bit_cnt_q;
    wait_d    = wait_q;
    mosi_d    = mosi_q;

    unique case (state_q)
      StIdle: begin
        if (start_edge) begin
          tx_d      = in_bytes;
          ntx_d     = clamp_count(in_bytes_count);
          nrx_d     = clamp_count(out_bytes_count);
          rx_d      = '0;
          bit_cnt_d = '0;
          wait_d    = '0;
          if (ntx_d == 3'd0 && nrx_d == 3'd0) begin
            out_d   = '0;
            state_d = StDone;
          end else begin
            state_d = StCsSetup;
          end
        end
      end
      StCsSetup: begin
        if (wait_end) begin
          wait_d  = '0;
          state_d = (ntx_q != 3'd0) ? StTx : StRx;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StTx: begin
        // Byte index in the upper count bits, MSB-first bit index in the lower three.
        if (rise_tick) mosi_d = tx_q[{bit_cnt_q[4:3], ~bit_cnt_q[2:0]}];
        if (fall_tick) begin
          if (last_tx) begin
            bit_cnt_d = '0;
            state_d   = (nrx_q != 3'd0) ? StRx : StCsHold;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      StRx: begin
        if (rise_tick) mosi_d = 1'b0;
        if (fall_tick) begin
          rx_d = {rx_q[DATA_W-2:0], din};
          if (last_rx) begin
            bit_cnt_d = '0;
            state_d   = StCsHold;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      StCsHold: begin
        if (wait_end) begin
          wait_d  = '0;
          mosi_d  = 1'b0;
          out_d   = rx_q;
          state_d = StDone;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    cs_d   = (state_d == StCsSetup) || (state_d == StTx) ||
             (state_d == StRx) || (state_d == StCsHold);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      tx_q      <= '0;
      rx_q      <= '0;
      out_q     <= '0;
      ntx_q     <= '0;
      nrx_q     <= '0;
      bit_cnt_q <= '0;
      wait_q    <= '0;
      mosi_q    <= 1'b0;
      cs_q      <= 1'b0;
      done_q    <= 1'b0;
      sync_q    <= '0;
      prev_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      out_q     <= out_d;
      ntx_q     <= ntx_d;
      nrx_q     <= nrx_d;
      bit_cnt_q <= bit_cnt_d;
      wait_q    <= wait_d;
      mosi_q    <= mosi_d;
      cs_q      <= cs_d;
      done_q    <= done_d;
      sync_q    <= {sync_q[0], start_trans};
      prev_q    <= sync_q[1];
    end
  end

  assign sck_out    = sck_lvl;
  assign mosi       = mosi_q;
  assign cs         = cs_q;
  assign out_bytes  = out_q;
  assign trans_done = done_q;

endmodule

// File: tb/tb_spi_byte_master.sv
// Directed bench for spi_byte_master (CLK_DIV=2) with a mode-1 slave model driving miso on SCK rise.
module tb_spi_byte_master;

`ifdef SPI_LOOPBACK_EN
  localparam bit Loopback = 1'b1;
`else
  localparam bit Loopback = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_trans = 1'b0;
  logic [3:0]  in_bytes_count = '0;
  logic [3:0]  out_bytes_count = '0;
  logic [31:0] in_bytes = '0;
  logic        miso = 1'b0;
  logic        sck_out, mosi, cs, trans_done;
  logic [31:0] out_bytes;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Slave model / monitors
  int unsigned rise_cnt = 0;
  int unsigned fall_cnt = 0;
  int unsigned done_cnt = 0;
  int unsigned skip_bits = 0;
  int unsigned rx_bits = 0;
  logic [31:0] slave_data = '0;
  logic [31:0] mosi_bits = '0;
  bit          cs_seen = 1'b0;

  spi_byte_master #(
    .CLK_DIV (2)
  ) dut (
    .clk_in          (clk_in),
    .rst_n           (rst_n),
    .start_trans     (start_trans),
    .in_bytes_count  (in_bytes_count),
    .out_bytes_count (out_bytes_count),
    .in_bytes        (in_bytes),
    .miso            (miso),
    .sck_out         (sck_out),
    .mosi            (mosi),
    .cs              (cs),
    .out_bytes       (out_bytes),
    .trans_done      (trans_done)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge sck_out) begin
    rise_cnt = rise_cnt + 1;
    if (rise_cnt > skip_bits && rise_cnt <= skip_bits + rx_bits)
      miso = slave_data[skip_bits + rx_bits - rise_cnt];
  end

  always @(negedge sck_out) begin
    if (cs) begin
      mosi_bits = {mosi_bits[30:0], mosi};
      fall_cnt  = fall_cnt + 1;
    end
  end

  always @(posedge clk_in) begin
    if (trans_done) done_cnt = done_cnt + 1;
    if (cs) cs_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rx(input logic [31:0] v);
    return Loopback ? 32'h0 : v;
  endfunction

  task automatic arm(input int unsigned ntx, input int unsigned nrx, input logic [31:0] sdata);
    rise_cnt   = 0;
    fall_cnt   = 0;
    done_cnt   = 0;
    mosi_bits  = '0;
    cs_seen    = 1'b0;
    miso       = 1'b0;
    skip_bits  = ntx * 8;
    rx_bits    = nrx * 8;
    slave_data = sdata;
  endtask

  task automatic pulse_start();
    @(posedge clk_in); #1 start_trans = 1'b1;
    repeat (4) @(posedge clk_in);
    #1 start_trans = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 2000 && done_cnt == 0; i++) @(posedge clk_in);
    check(tag, 32'(done_cnt != 0), 32'd1);
    repeat (20) @(posedge clk_in);
    #1;
  endtask

  initial begin
    // 1. reset while idle
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_cs", 32'(cs), 32'd0);
    check("rst_sck", 32'(sck_out), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_out", out_bytes, 32'h0);
    check("rst_done", 32'(trans_done), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk_in);

    // 2. command/response
    arm(1, 1, 32'h03);
    in_bytes_count = 4'd1; out_bytes_count = 4'd1; in_bytes = 32'h01;
    pulse_start();
    wait_done("t2_timeout");
    check("t2_sck", fall_cnt, 32'd16);
    check("t2_mosi", mosi_bits, 32'h0000_0100);
    check("t2_out", out_bytes, exp_rx(32'h03));
    check("t2_done", done_cnt, 32'd1);

    // 3. three-byte write
    arm(3, 0, 32'h0);
    in_bytes_count = 4'd3; out_bytes_count = 4'd0; in_bytes = 32'h0080_8103;
    pulse_start();
    wait_done("t3_timeout");
    check("t3_sck", fall_cnt, 32'd24);
    check("t3_mosi", mosi_bits, 32'h0003_8180);
    check("t3_out", out_bytes, 32'h0);

    // 4. one-byte write, two-byte read
    arm(1, 2, 32'h8103);
    in_bytes_count = 4'd1; out_bytes_count = 4'd2; in_bytes = 32'hA5;
    pulse_start();
    wait_done("t4_timeout");
    check("t4_mosi", mosi_bits, 32'h00A5_0000);
    check("t4_out", out_bytes, exp_rx(32'h0000_8103));

    // 5a. second start edge while busy is ignored
    arm(1, 1, 32'hC3);
    in_bytes_count = 4'd1; out_bytes_count = 4'd1; in_bytes = 32'h5A;
    pulse_start();
    repeat (6) @(posedge clk_in);
    pulse_start();
    wait_done("t5a_timeout");
    repeat (100) @(posedge clk_in);
    #1;
    check("t5a_done", done_cnt, 32'd1);
    check("t5a_out", out_bytes, exp_rx(32'hC3));

    // 5b. zero-length transfer
    arm(0, 0, 32'h0);
    in_bytes_count = 4'd0; out_bytes_count = 4'd0; in_bytes = 32'hFFFF_FFFF;
    pulse_start();
    wait_done("t5b_timeout");
    check("t5b_done", done_cnt, 32'd1);
    check("t5b_cs", 32'(cs_seen), 32'd0);
    check("t5b_sck", fall_cnt, 32'd0);
    check("t5b_out", out_bytes, 32'h0);

    // 5c. oversized tx count clamps to 4
    arm(4, 0, 32'h0);
    in_bytes_count = 4'd9; out_bytes_count = 4'd0; in_bytes = 32'h4433_2211;
    pulse_start();
    wait_done("t5c_timeout");
    check("t5c_sck", fall_cnt, 32'd32);
    check("t5c_mosi", mosi_bits, 32'h1122_3344);

    // 6. reset mid-tx
    arm(2, 2, 32'h0);
    in_bytes_count = 4'd2; out_bytes_count = 4'd2; in_bytes = 32'hFFFF;
    pulse_start();
    for (int i = 0; i < 2000 && fall_cnt < 4; i++) @(posedge clk_in);
    check("t6_reach_tx", 32'(fall_cnt >= 4), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_cs", 32'(cs), 32'd0);
    check("t6_sck", 32'(sck_out), 32'd0);
    repeat (2) @(posedge clk_in);
    #1 rst_n = 1'b1;
    repeat (100) @(posedge clk_in);
    #1;
    check("t6_no_done", done_cnt, 32'd0);
    arm(1, 1, 32'h42);
    in_bytes_count = 4'd1; out_bytes_count = 4'd1; in_bytes = 32'h7E;
    pulse_start();
    wait_done("t6_timeout");
    check("t6_mosi", mosi_bits, 32'h0000_7E00);
    check("t6_out", out_bytes, exp_rx(32'h42));
    check("t6_done", done_cnt, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
